// File: rtl/spi_tx_shifter_pkg.sv
// Shared types and helpers for the SPI MISO transmit engine.
package spi_tx_shifter_pkg;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} tx_state_t;

    localparam int DEF_WORD_BYTES = 4;
    localparam int DEF_ECC_W      = 6;
    localparam int WORD_W         = DEF_WORD_BYTES * 8 + DEF_ECC_W;

    function automatic int word_width(input int word_bytes, input int ecc_w);
        return word_bytes * 8 + ecc_w;
    endfunction

    // The ECC lane is only transmitted when ECC bits exist and are not hidden.
    function automatic int last_lane(input int word_bytes, input int ecc_w, input logic ecc_en);
        return (ecc_en || ecc_w == 0) ? word_bytes - 1 : word_bytes;
    endfunction

endpackage

// File: rtl/spi_tx_shifter_lane_mux.sv
// Byte-lane selector: data lanes 0..WORD_BYTES-1, ECC lane WORD_BYTES (zero padded).
module spi_tx_lane_mux
    import spi_tx_shifter_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter int ECC_W      = 6,
    parameter int LANE_W     = 3
) (
    input  logic [word_width(WORD_BYTES, ECC_W)-1:0] word,
    input  logic [LANE_W-1:0]                        lane,
    output logic [7:0]                               lane_byte
);
    localparam int WW = word_width(WORD_BYTES, ECC_W);

    logic [7:0] lanes [WORD_BYTES+1];

    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_data_lane
            assign lanes[gi] = word[gi*8 +: 8];
        end
        if (ECC_W > 0) begin : g_ecc_lane
            assign lanes[WORD_BYTES] = 8'(word[WW-1:WORD_BYTES*8]);
        end else begin : g_no_ecc_lane
            assign lanes[WORD_BYTES] = 8'h00;
        end
    endgenerate

    always_comb begin
        lane_byte = 8'h00;
        for (int i = 0; i <= WORD_BYTES; i++) begin
            if (lane == LANE_W'(i)) lane_byte = lanes[i];
        end
    end

endmodule

// File: rtl/spi_tx_shifter.sv
// SPI slave MISO engine: serialises memory word lanes or the status register, MSB first,
// with burst lane advance, word refill requests and underrun detection.
module spi_tx_shifter
    import spi_tx_shifter_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter int ECC_W      = 6,
    parameter int STAT_W     = 8,
    parameter int LANE_W     = 3
) (
    input  logic                                     spi_clk_c,
    input  logic                                     spi_frm_rst_n,
    input  logic                                     spi_tx_start,
    input  logic                                     spi_rd_active,
    input  logic                                     spi_cmd_rdsr,
    input  logic                                     spi_ecc_en,
    input  logic                                     spi_tcmd_ecc_bist3,
    input  logic [LANE_W-1:0]                        spi_start_lane,
    input  logic [word_width(WORD_BYTES, ECC_W)-1:0] spi_data_in,
    input  logic                                     spi_data_vld,
    input  logic [STAT_W-1:0]                        spi_status_reg,
    output logic                                     spi_word_req,
    output logic                                     spi_byte_done,
    output logic                                     spi_sda_out,
    output logic                                     spi_sda_out_en,
    output logic                                     spi_tx_underrun
);
    localparam int WW = word_width(WORD_BYTES, ECC_W);

    tx_state_t         state_reg;
    logic [2:0]        bit_cnt_reg;
    logic [7:0]        shift_reg;
    logic [LANE_W-1:0] lane_reg;
    logic [WW-1:0]     word_buf_reg;
    logic              buf_valid_reg;
    logic              pending_reg;
    logic              short_byte_reg;   // current byte was an underrun filler

    logic [LANE_W-1:0] last_lane_c, start_lane_c, next_lane_c, mux_lane_c;
    logic [WW-1:0]     mux_word_c;
    logic [7:0]        lane_byte_c, status_byte_c;
    logic              word_avail_c, needs_refill_c, load_c;

    assign last_lane_c   = LANE_W'(last_lane(WORD_BYTES, ECC_W, spi_ecc_en));
    assign status_byte_c = 8'(spi_status_reg) << (8 - STAT_W);

    always_comb begin
        start_lane_c = spi_start_lane;
        if (spi_tcmd_ecc_bist3 || spi_start_lane > last_lane_c) start_lane_c = '0;
        next_lane_c = lane_reg + 1'b1;
        if (short_byte_reg) next_lane_c = lane_reg;
        else if (spi_tcmd_ecc_bist3 || lane_reg >= last_lane_c) next_lane_c = '0;
        mux_lane_c     = spi_tx_start ? start_lane_c : next_lane_c;
        // A word arriving exactly on the reload edge is used directly.
        mux_word_c     = (spi_tx_start || !buf_valid_reg) ? spi_data_in : word_buf_reg;
        word_avail_c   = spi_tx_start ? spi_data_vld
                                      : (buf_valid_reg || (pending_reg && spi_data_vld));
        needs_refill_c = spi_tcmd_ecc_bist3 || (mux_lane_c == last_lane_c);
    end

    assign load_c = spi_tx_start ||
                    (state_reg == SHIFT && spi_rd_active && bit_cnt_reg == 3'd0);

    spi_tx_lane_mux #(
        .WORD_BYTES (WORD_BYTES),
        .ECC_W      (ECC_W),
        .LANE_W     (LANE_W)
    ) u_lane_mux (
        .word      (mux_word_c),
        .lane      (mux_lane_c),
        .lane_byte (lane_byte_c)
    );

    always_ff @(posedge spi_clk_c or negedge spi_frm_rst_n) begin
        if (!spi_frm_rst_n) begin
            state_reg       <= IDLE;
            bit_cnt_reg     <= 3'd7;
            shift_reg       <= '0;
            lane_reg        <= '0;
            word_buf_reg    <= '0;
            buf_valid_reg   <= 1'b0;
            pending_reg     <= 1'b0;
            short_byte_reg  <= 1'b0;
            spi_sda_out     <= 1'b1;
            spi_sda_out_en  <= 1'b0;
            spi_word_req    <= 1'b0;
            spi_byte_done   <= 1'b0;
            spi_tx_underrun <= 1'b0;
        end else begin
            spi_word_req  <= 1'b0;
            spi_byte_done <= 1'b0;
            if (load_c) begin
                state_reg      <= SHIFT;
                spi_sda_out_en <= 1'b1;
                bit_cnt_reg    <= 3'd7;
                if (spi_tx_start) spi_tx_underrun <= 1'b0;
                if (spi_cmd_rdsr) begin
                    shift_reg      <= status_byte_c;
                    spi_sda_out    <= status_byte_c[7];
                    short_byte_reg <= 1'b0;
                    buf_valid_reg  <= 1'b0;
                    pending_reg    <= 1'b0;
                end else if (word_avail_c) begin
                    shift_reg      <= lane_byte_c;
                    spi_sda_out    <= lane_byte_c[7];
                    lane_reg       <= mux_lane_c;
                    short_byte_reg <= 1'b0;
                    if (needs_refill_c) begin
                        spi_word_req  <= 1'b1;
                        pending_reg   <= 1'b1;
                        buf_valid_reg <= 1'b0;
                    end else begin
                        word_buf_reg  <= mux_word_c;
                        buf_valid_reg <= 1'b1;
                        pending_reg   <= 1'b0;
                    end
                end else begin
                    // Underrun: send zeros, keep the request open, retry this lane next byte.
                    shift_reg       <= '0;
                    spi_sda_out     <= 1'b0;
                    lane_reg        <= mux_lane_c;
                    short_byte_reg  <= 1'b1;
                    spi_tx_underrun <= 1'b1;
                    pending_reg     <= 1'b1;
                    buf_valid_reg   <= 1'b0;
                end
            end else if (!spi_rd_active || state_reg == IDLE) begin
                state_reg      <= IDLE;
                spi_sda_out    <= 1'b0;
                spi_sda_out_en <= 1'b0;
                bit_cnt_reg    <= 3'd7;
                lane_reg       <= '0;
                buf_valid_reg  <= 1'b0;
                pending_reg    <= 1'b0;
                short_byte_reg <= 1'b0;
            end else begin
                bit_cnt_reg   <= bit_cnt_reg - 3'd1;
                spi_sda_out   <= shift_reg[bit_cnt_reg - 3'd1];
                spi_byte_done <= (bit_cnt_reg == 3'd1);
                if (pending_reg && spi_data_vld) begin
                    word_buf_reg  <= spi_data_in;
                    buf_valid_reg <= 1'b1;
                    pending_reg   <= 1'b0;
                end
            end
        end
    end

endmodule
